// File: rtl/ingress_packetizer_arbiter.sv
// Round-robin arbiter that shares one packetizer ingress between C_NUM_REQ sources.
// Define PACKETIZER_ARB_BURST_LOCK_EN to hold a grant for up to C_MAX_BURST beats.
module ingress_packetizer_arbiter #(
  parameter int unsigned C_NUM_REQ              = 4,
  parameter int unsigned C_PACKET_PAYLOAD_WIDTH = 128,
  parameter int unsigned C_MAX_BURST            = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [C_NUM_REQ-1:0]                        req_valid,
  output logic [C_NUM_REQ-1:0]                        req_ready,
  input  logic [C_NUM_REQ*C_PACKET_PAYLOAD_WIDTH-1:0] req_data,
  input  logic [C_NUM_REQ*2-1:0]                      req_mode,
  input  logic [C_NUM_REQ*8-1:0]                      req_option,
  output logic                                        pkt_valid,
  input  logic                                        pkt_ready,
  output logic [C_PACKET_PAYLOAD_WIDTH-1:0]           pkt_data,
  output logic [1:0]                                  pkt_mode,
  output logic [7:0]                                  pkt_option,
  output logic [C_NUM_REQ-1:0]                        grant,
  output logic                                        busy
);

  localparam int unsigned IdxW = $clog2(C_NUM_REQ);
  localparam int unsigned W    = C_PACKET_PAYLOAD_WIDTH;

  if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_MAX_BURST < 1 || C_MAX_BURST > 256) begin : g_bad_cfg
    $error("ingress_packetizer_arbiter: parameter out of range");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [C_NUM_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          option_q, option_d;

  logic                sel_found;
  logic [IdxW-1:0]     sel_idx;
  logic [IdxW:0]       cand;
  logic [1:0]          sel_mode;
  logic [7:0]          sel_option;
  logic                gvalid;
  logic                burst_done;
  logic                rel_grant;

  assign gvalid = req_valid[gidx_q];

`ifdef PACKETIZER_ARB_BURST_LOCK_EN
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;
  logic       beat;

  // Nine bits so a C_MAX_BURST of 256 is still reachable from a saturating 8-bit count.
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign burst_done = (cnt_inc >= 9'(C_MAX_BURST));
  assign beat       = (state_q == StGrant) && gvalid && pkt_ready;
`else
  assign burst_done = 1'b1;
`endif

  assign rel_grant = (state_q == StGrant) && (!gvalid || (pkt_ready && burst_done));

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    cand       = '0;
    sel_mode   = '0;
    sel_option = '0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(C_NUM_REQ)) begin
        cand = cand - (IdxW+1)'(C_NUM_REQ);
      end
      if (!sel_found && req_valid[cand[IdxW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IdxW-1:0];
      end
    end
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_mode   = req_mode[2*i +: 2];
        sel_option = req_option[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      mode_q   <= '0;
      option_q <= '0;
`ifdef PACKETIZER_ARB_BURST_LOCK_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      option_q <= option_d;
`ifdef PACKETIZER_ARB_BURST_LOCK_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    option_d = option_q;
`ifdef PACKETIZER_ARB_BURST_LOCK_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d          = StGrant;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          mode_d           = sel_mode;
          option_d         = sel_option;
`ifdef PACKETIZER_ARB_BURST_LOCK_EN
          cnt_d            = '0;
`endif
        end
      end
      StGrant: begin
`ifdef PACKETIZER_ARB_BURST_LOCK_EN
        if (beat) begin
          cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
        end
`endif
        if (rel_grant) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = (gidx_q == IdxW'(C_NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q == StGrant);
    grant      = grant_q;
    pkt_mode   = mode_q;
    pkt_option = option_q;
    pkt_valid  = busy && gvalid;
    pkt_data   = '0;
    req_ready  = '0;
    if (busy) begin
      for (int i = 0; i < C_NUM_REQ; i++) begin
        if (gidx_q == IdxW'(i)) begin
          pkt_data     = req_data[i*W +: W];
          req_ready[i] = pkt_ready;
        end
      end
    end
  end

endmodule
